// File: rtl/ucode_seq_pkg.sv
// Shared types and constants for the ucode_seq micro-op sequencer.
// ucode_word_t describes the default W=32 layout; narrower or wider W keeps the same header.
package ucode_seq_pkg;

    localparam int unsigned UCODE_OP_W  = 4;
    localparam int unsigned UCODE_IDX_W = 8;
    localparam int unsigned UCODE_HDR_W = UCODE_OP_W + 1 + UCODE_IDX_W;
    localparam int unsigned UCODE_DEF_W = 32;
    localparam int unsigned UCODE_ARG_W = UCODE_DEF_W - UCODE_HDR_W;

    localparam logic [15:0] UCODE_SEQ_CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE,
        ISSUE
    } ucode_seq_state_t;

    typedef struct packed {
        logic [UCODE_OP_W-1:0]  op;
        logic                   last;
        logic [UCODE_IDX_W-1:0] idx;
        logic [UCODE_ARG_W-1:0] arg;
    } ucode_word_t;

endpackage

// File: rtl/ucode_seq_fmt.sv
// Combinational ucode word formatter: packs op, last flag, beat index and base+idx argument.
module ucode_seq_fmt
    import ucode_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [UCODE_OP_W-1:0]    op,
    input  logic [UCODE_IDX_W-1:0]   len,
    input  logic [W-UCODE_HDR_W-1:0] base,
    input  logic [UCODE_IDX_W-1:0]   idx,
    output logic [W-1:0]             word
);

    localparam int unsigned ARG_W = W - UCODE_HDR_W;

    logic             last;
    logic [ARG_W-1:0] arg;

    always_comb begin
        last = (idx == len);
        // Carry out of the argument field is intentionally dropped.
        arg  = base + ARG_W'(idx);
        word = {op, last, idx, arg};
    end

endmodule

// File: rtl/ucode_seq.sv
// Micro-op sequencer: expands one command into 1..256 registered ucode words.
// Optional UCODE_SEQ_FLUSH_EN adds a flush input that abandons the current burst.
module ucode_seq
    import ucode_seq_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_vld,
    input  logic [UCODE_OP_W-1:0]  cmd_op,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic [W-UCODE_HDR_W-1:0] cmd_arg,
    output logic                   cmd_accept,
    output logic [W-1:0]           out_r,
    output logic                   out_vld_r,
    input  logic                   out_accept,
    output logic                   busy_r,
    output logic [15:0]            beat_cnt_r
`ifdef UCODE_SEQ_FLUSH_EN
    ,
    input  logic                   flush
`endif
);

    localparam int unsigned ARG_W = W - UCODE_HDR_W;

    ucode_seq_state_t state_q, state_d;

    logic [UCODE_OP_W-1:0] op_q, op_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [ARG_W-1:0]      arg_q, arg_d;
    logic [W-1:0]          out_d;
    logic                  vld_d;
    logic [15:0]           cnt_d;

    logic                  flush_act;
    logic                  xfer;
    logic                  last_beat;
    logic                  take;

    logic [UCODE_OP_W-1:0] f_op;
    logic [LEN_W-1:0]      f_len;
    logic [ARG_W-1:0]      f_base;
    logic [LEN_W-1:0]      f_idx;
    logic [W-1:0]          f_word;

`ifdef UCODE_SEQ_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign busy_r = (state_q == ISSUE);

    always_comb begin
        xfer       = out_vld_r & out_accept;
        last_beat  = out_r[W-UCODE_OP_W-1];
        cmd_accept = ~flush_act &
                     ((state_q == IDLE) | ((state_q == ISSUE) & xfer & last_beat));
        take       = cmd_vld & cmd_accept;
    end

    // Formatter sees either the incoming command at idx 0 or the held command at idx+1.
    always_comb begin
        if (take) begin
            f_op   = cmd_op;
            f_len  = cmd_len;
            f_base = cmd_arg;
            f_idx  = '0;
        end else begin
            f_op   = op_q;
            f_len  = len_q;
            f_base = arg_q;
            f_idx  = idx_q + 1'b1;
        end
    end

    ucode_seq_fmt #(
        .W (W)
    ) u_fmt (
        .op   (f_op),
        .len  (f_len),
        .base (f_base),
        .idx  (f_idx),
        .word (f_word)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        arg_d   = arg_q;
        idx_d   = idx_q;
        out_d   = out_r;
        vld_d   = out_vld_r;
        cnt_d   = beat_cnt_r;

        if (xfer && beat_cnt_r != UCODE_SEQ_CNT_MAX) begin
            cnt_d = beat_cnt_r + 16'd1;
        end

        if (take) begin
            state_d = ISSUE;
            op_d    = cmd_op;
            len_d   = cmd_len;
            arg_d   = cmd_arg;
            idx_d   = '0;
            out_d   = f_word;
            vld_d   = 1'b1;
        end else if (flush_act) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else if (state_q == ISSUE && xfer) begin
            if (last_beat) begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end else begin
                idx_d = f_idx;
                out_d = f_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            len_q      <= '0;
            arg_q      <= '0;
            idx_q      <= '0;
            out_r      <= '0;
            out_vld_r  <= 1'b0;
            beat_cnt_r <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            arg_q      <= arg_d;
            idx_q      <= idx_d;
            out_r      <= out_d;
            out_vld_r  <= vld_d;
            beat_cnt_r <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ucode_seq.sv
// Self-checking bench for ucode_seq: a queue-of-words reference model checked every cycle.
// Flush scenarios are exercised only when UCODE_SEQ_FLUSH_EN is defined.
module tb_ucode_seq;
    import ucode_seq_pkg::*;

    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic [3:0]  cmd_op = '0;
    logic [7:0]  cmd_len = '0;
    logic [18:0] cmd_arg = '0;
    logic        cmd_accept;
    logic [31:0] out_r;
    logic        out_vld_r;
    logic        out_accept = 1'b1;
    logic        busy_r;
    logic [15:0] beat_cnt_r;
    logic        flush = 1'b0;

    always #5 clk = ~clk;

    ucode_seq #(
        .W     (W),
        .LEN_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_vld    (cmd_vld),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .cmd_arg    (cmd_arg),
        .cmd_accept (cmd_accept),
        .out_r      (out_r),
        .out_vld_r  (out_vld_r),
        .out_accept (out_accept),
        .busy_r     (busy_r),
        .beat_cnt_r (beat_cnt_r)
`ifdef UCODE_SEQ_FLUSH_EN
        ,
        .flush      (flush)
`endif
    );

    // Reference model: words still owed by the in-flight command, plus transfer count.
    logic [31:0] exp_q[$];
    int unsigned m_cnt = 0;
    bit          m_took = 1'b0;
    bit          rand_acc = 1'b0;
    int unsigned acc_pct = 100;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_word(input logic [3:0] op, input logic [7:0] len,
                                            input logic [18:0] arg, input logic [7:0] idx);
        ucode_word_t w;
        w.op   = op;
        w.last = (idx == len);
        w.idx  = idx;
        w.arg  = arg + {11'd0, idx};
        return w;
    endfunction

    task automatic cycle();
        bit xfer;
        bit acc;
        @(negedge clk);
        xfer = (exp_q.size() > 0) && out_accept;
        acc  = !flush && ((exp_q.size() == 0) || (xfer && exp_q.size() == 1));
        check_val("cmd_accept", cmd_accept, acc);
        check_val("out_vld_r", out_vld_r, exp_q.size() > 0);
        check_val("busy_r", busy_r, exp_q.size() > 0);
        check_val("beat_cnt_r", beat_cnt_r, m_cnt);
        if (exp_q.size() > 0) check_val("out_r", out_r, exp_q[0]);
        @(posedge clk);
        m_took = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (xfer) begin
                if (m_cnt < 65535) m_cnt++;
                void'(exp_q.pop_front());
            end
            if (flush) begin
                exp_q.delete();
            end else if (cmd_vld && acc) begin
                m_took = 1'b1;
                for (int i = 0; i <= int'(cmd_len); i++)
                    exp_q.push_back(mk_word(cmd_op, cmd_len, cmd_arg, 8'(i)));
            end
        end
        #1;
        if (rand_acc) out_accept = ($urandom_range(99) < acc_pct);
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [7:0] len, input logic [18:0] arg);
        int n = 0;
        cmd_op  = op;
        cmd_len = len;
        cmd_arg = arg;
        cmd_vld = 1'b1;
        do begin
            cycle();
            n++;
        end while (!m_took && n < 2000);
        if (!m_took) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_wait: command not taken after %0d cycles", n);
        end
        cmd_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_val("rst_out_r", out_r, 32'h0);
        cycle();

        // Single-beat command
        send_cmd(4'h3, 8'd0, 19'h100);
        check_val("t1_word", out_r, {4'h3, 1'b1, 8'h00, 19'h100});
        drain();
        cycle();
        check_val("t1_cnt", beat_cnt_r, 16'd1);

        // Argument wrap across the 19-bit field
        send_cmd(4'h5, 8'd3, 19'h7FFFE);
        drain();
        cycle();

        // Back-to-back commands chained on the last transfer
        send_cmd(4'h1, 8'd1, 19'h20);
        send_cmd(4'h2, 8'd2, 19'h40);
        drain();
        cycle();

        // Sink stall on idx 1
        out_accept = 1'b1;
        send_cmd(4'h7, 8'd2, 19'h55);
        cycle();
        out_accept = 1'b0;
        held = out_r;
        repeat (3) begin
            cycle();
            check_val("stall_hold", out_r, held);
        end
        out_accept = 1'b1;
        drain();
        cycle();

        // Max-length burst with random back-pressure
        do_reset();
        rand_acc = 1'b1;
        acc_pct  = 60;
        send_cmd(4'hA, 8'd255, 19'h3FF00);
        drain();
        rand_acc   = 1'b0;
        out_accept = 1'b1;
        check_val("t5_cnt", beat_cnt_r, 16'd256);
        cycle();

        // Random commands, gaps and back-pressure
        rand_acc = 1'b1;
        acc_pct  = 70;
        for (int c = 0; c < 40; c++) begin
            send_cmd(4'($urandom), 8'($urandom_range(15)), 19'($urandom));
            if ($urandom_range(3) == 0) begin
                for (int g = 0; g < int'($urandom_range(2)); g++) cycle();
            end
        end
        drain();
        rand_acc   = 1'b0;
        out_accept = 1'b1;
        cycle();

        // Reset mid-burst
        send_cmd(4'h9, 8'd7, 19'h1);
        repeat (3) cycle();
        do_reset();
        cycle();
        check_val("rst_mid_cnt", beat_cnt_r, 16'd0);
        check_val("rst_mid_vld", out_vld_r, 1'b0);
        send_cmd(4'h4, 8'd1, 19'h10);
        drain();
        cycle();

`ifdef UCODE_SEQ_FLUSH_EN
        // Flush at idx 2 of an 8-beat command
        send_cmd(4'hC, 8'd7, 19'h200);
        repeat (2) cycle();
        check_val("flush_idx", out_r[18+8:19], 8'd2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check_val("flush_vld", out_vld_r, 1'b0);
        check_val("flush_busy", busy_r, 1'b0);
        send_cmd(4'hD, 8'd2, 19'h300);
        check_val("flush_next_idx0", out_r, {4'hD, 1'b0, 8'h00, 19'h300});
        drain();
        cycle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
